// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM encodings and iteration count for the sequential ALU.
package seq_alu_pkg;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_DIV  = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } state_t;

    // One iteration per operand bit for the current 16-bit CPU.
    localparam int ITER_COUNT = 16;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative shift-add multiply core; restoring divide added when SEQ_ALU_DIV_EN is defined.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = ITER_COUNT,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
`ifdef SEQ_ALU_DIV_EN
    input  logic             div_sel,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    logic [2*WIDTH-1:0] partial_q, partial_nxt;
    logic [2*WIDTH-1:0] mcand_q, mcand_nxt;
    logic [WIDTH-1:0]   mplier_q, mplier_nxt;
    logic [CNT_W-1:0]   cnt_q;
`ifdef SEQ_ALU_DIV_EN
    logic               div_q;
    logic [WIDTH:0]     sh_rem;
    logic [WIDTH-1:0]   rem_sub;
`endif

    always_comb begin
        partial_nxt = partial_q + (mplier_q[0] ? mcand_q : '0);
        mcand_nxt   = mcand_q << 1;
        mplier_nxt  = mplier_q >> 1;
`ifdef SEQ_ALU_DIV_EN
        // partial = {remainder, quotient}; the divisor stays parked in mplier_q.
        sh_rem  = partial_q[2*WIDTH-1:WIDTH-1];
        rem_sub = sh_rem[WIDTH-1:0] - mplier_q;
        if (div_q) begin
            mcand_nxt  = mcand_q;
            mplier_nxt = mplier_q;
            if (sh_rem >= {1'b0, mplier_q})
                partial_nxt = {rem_sub, partial_q[WIDTH-2:0], 1'b1};
            else
                partial_nxt = {sh_rem[WIDTH-1:0], partial_q[WIDTH-2:0], 1'b0};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial_q <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q     <= 1'b0;
`endif
        end else if (load) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q     <= div_sel;
            partial_q <= div_sel ? {{WIDTH{1'b0}}, a} : '0;
`else
            partial_q <= '0;
`endif
        end else if (step) begin
            partial_q <= partial_nxt;
            mcand_q   <= mcand_nxt;
            mplier_q  <= mplier_nxt;
            cnt_q     <= cnt_q + CNT_W'(1);
        end
    end

    // High half is the product overflow for MUL and the remainder for DIV.
    assign last   = (cnt_q == CNT_W'(WIDTH - 1));
    assign result = partial_nxt[WIDTH-1:0];
    assign flag   = |partial_nxt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU feeding the accumulator c_bus; define SEQ_ALU_DIV_EN to enable opcode 111 (DIV).
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = ITER_COUNT,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] c_bus,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_nxt;
    logic             iter_load, iter_step, iter_last, iter_flag;
    logic [WIDTH-1:0] iter_result;
    logic             res_we, res_flag, done_nxt;
    logic [WIDTH-1:0] res_val;
    logic [WIDTH:0]   single_res;
`ifdef SEQ_ALU_DIV_EN
    logic             div_sel;
`endif

    // Returns {flag, value} for the single-cycle opcodes.
    function automatic logic [WIDTH:0] single_op(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            OP_ADD:  single_op = {1'b0, a} + {1'b0, b};
            OP_SUB:  single_op = {(a >= b), a - b};
            OP_AND:  single_op = {1'b0, a & b};
            OP_OR:   single_op = {1'b0, a | b};
            OP_SHL:  single_op = {a, 1'b0};
            default: single_op = {1'b0, b};
        endcase
    endfunction

    assign single_res = single_op(alu_op, a_in, b_in);

    seq_alu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (iter_load),
        .step    (iter_step),
`ifdef SEQ_ALU_DIV_EN
        .div_sel (div_sel),
`endif
        .a       (a_in),
        .b       (b_in),
        .last    (iter_last),
        .result  (iter_result),
        .flag    (iter_flag)
    );

    always_comb begin
        state_nxt = state_q;
        iter_load = 1'b0;
        iter_step = 1'b0;
        res_we    = 1'b0;
        res_val   = c_bus;
        res_flag  = carry;
        done_nxt  = 1'b0;
`ifdef SEQ_ALU_DIV_EN
        div_sel   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (alu_op)
                        OP_MUL: begin
                            iter_load = 1'b1;
                            state_nxt = ST_ITER;
                        end
                        OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
                            if (b_in == '0) begin
                                res_we   = 1'b1;
                                res_val  = '1;
                                res_flag = 1'b1;
                                done_nxt = 1'b1;
                            end else begin
                                iter_load = 1'b1;
                                div_sel   = 1'b1;
                                state_nxt = ST_ITER;
                            end
`else
                            // Illegal opcode: acknowledge but leave results untouched.
                            done_nxt = 1'b1;
`endif
                        end
                        default: begin
                            res_we   = 1'b1;
                            res_val  = single_res[WIDTH-1:0];
                            res_flag = single_res[WIDTH];
                            done_nxt = 1'b1;
                        end
                    endcase
                end
            end
            ST_ITER: begin
                iter_step = 1'b1;
                if (iter_last) begin
                    res_we    = 1'b1;
                    res_val   = iter_result;
                    res_flag  = iter_flag;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            c_bus   <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            done    <= done_nxt;
            if (res_we) begin
                c_bus <= res_val;
                carry <= res_flag;
                zero  <= (res_val == '0);
            end
        end
    end

    assign busy = (state_q == ST_ITER);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu; honours SEQ_ALU_DIV_EN for the opcode 111 vectors.
module tb_seq_alu;

    typedef struct {
        logic [15:0] val;
        logic        c;
        logic        z;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  alu_op = 3'd0;
    logic [15:0] a_in = 16'd0;
    logic [15:0] b_in = 16'd0;
    logic [15:0] c_bus;
    logic        carry, zero, busy, done;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_seen = 0;
    logic [15:0] m_val = 16'd0;
    logic        m_c = 1'b0;
    logic        m_z = 1'b0;

    seq_alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .alu_op (alu_op),
        .a_in   (a_in),
        .b_in   (b_in),
        .c_bus  (c_bus),
        .carry  (carry),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("c_bus", int'(c_bus), int'(e.val));
                check("carry", int'(carry), int'(e.c));
                check("zero", int'(zero), int'(e.z));
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic push_exp(input logic [15:0] v, input logic c, input int lat);
        exp_t e;
        e.val = v;
        e.c   = c;
        e.z   = (v == 16'd0);
        e.cyc = cyc + lat;
        sb.push_back(e);
        m_val = e.val;
        m_c   = e.c;
        m_z   = e.z;
    endtask

    // Drives one start pulse from the current (negedge) point; returns just after the sampling edge.
    task automatic drive_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        start  = 1'b1;
        alu_op = op;
        a_in   = a;
        b_in   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 16'hDEAD;
        b_in  = 16'hBEEF;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ev, input logic ec, input int lat);
        @(negedge clk);
        drive_op(op, a, b);
        push_exp(ev, ec, lat);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int k;
        int seen0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_c_bus", int'(c_bus), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0);   // ADD wrap
        wait_drain();
        issue(3'd2, 16'd3, 16'd5, 16'hFFFE, 1'b0, 0);          // SUB borrow
        wait_drain();
        issue(3'd2, 16'd9, 16'd9, 16'h0000, 1'b1, 0);          // SUB equal
        wait_drain();
        issue(3'd5, 16'h8001, 16'h0000, 16'h0002, 1'b1, 0);    // SHL
        wait_drain();
        issue(3'd0, 16'h5555, 16'h1234, 16'h1234, 1'b0, 0);    // PASS
        wait_drain();
        issue(3'd3, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 0);    // AND
        wait_drain();
        issue(3'd4, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 0);    // OR
        wait_drain();
        issue(3'd6, 16'd300, 16'd300, 16'h5F90, 1'b1, 16);     // MUL overflow
        wait_drain();
        issue(3'd6, 16'd12, 16'd11, 16'd132, 1'b0, 16);
        wait_drain();
        issue(3'd6, 16'd0, 16'd5, 16'd0, 1'b0, 16);
        wait_drain();

        // ADD during MUL iteration 5 is dropped; ADD in the done cycle is taken.
        issue(3'd6, 16'd7, 16'd9, 16'd63, 1'b0, 16);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("busy_mid_mul", int'(busy), 1);
        drive_op(3'd1, 16'd1, 16'd2);
        k = 0;
        @(negedge clk);
        while (done !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("mul_done_seen", int'(done), 1);
        drive_op(3'd1, 16'd5, 16'd6);
        push_exp(16'd11, 1'b0, 0);
        wait_drain();

`ifdef SEQ_ALU_DIV_EN
        issue(3'd7, 16'd100, 16'd7, 16'd14, 1'b1, 16);
        wait_drain();
        issue(3'd7, 16'd100, 16'd0, 16'hFFFF, 1'b1, 0);
        wait_drain();
        issue(3'd7, 16'd42, 16'd6, 16'd7, 1'b0, 16);
        wait_drain();
`else
        issue(3'd7, 16'd100, 16'd7, m_val, m_c, 0);            // illegal: result held
        wait_drain();
        check("illegal_zero_held", int'(zero), int'(m_z));
`endif

        // Reset in the middle of a MUL aborts it with no done pulse.
        issue(3'd0, 16'd0, 16'hABCD, 16'hABCD, 1'b0, 0);
        wait_drain();
        @(negedge clk);
        drive_op(3'd6, 16'd300, 16'd300);
        repeat (7) @(posedge clk);
        #2;
        check("busy_before_rst", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_c_bus", int'(c_bus), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        m_val = 16'd0;
        m_c   = 1'b0;
        m_z   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen0 = done_seen;
        repeat (24) @(negedge clk);
        check("no_done_after_abort", done_seen, seen0);
        check("c_bus_after_abort", int'(c_bus), 0);

        issue(3'd1, 16'd2, 16'd3, 16'd5, 1'b0, 0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
